// File: rtl/bin_to_digit_converter_if.sv
// Handshake and digit bus between the converter and its producer/display.
// Master drives value/start; slave returns status and digit codes.
interface bin_to_digit_converter_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] value;
    logic             start;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [5:0]       digit3;
    logic [5:0]       digit2;
    logic [5:0]       digit1;
    logic [5:0]       digit0;

    modport master (
        output value, start,
        input  busy, done, overflow,
        input  digit3, digit2, digit1, digit0
    );

    modport slave (
        input  value, start,
        output busy, done, overflow,
        output digit3, digit2, digit1, digit0
    );
endinterface

// File: rtl/bin_to_digit_converter.sv
// Sequential double-dabble binary-to-decimal converter for a 4-digit display.
// Optional macro BLANK_LEADING_ZEROS_EN blanks leading zero digits (digit0 kept).
module bin_to_digit_converter #(
    parameter int WIDTH     = 14,
    parameter int MAX_VALUE = 9999
) (
    input logic                     clk,
    input logic                     rst_n,
    bin_to_digit_converter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_e;

    localparam logic [5:0]  OFF      = 6'd16;
    localparam logic [5:0]  DASH     = 6'd17;
    localparam logic [3:0]  CNT_INIT = 4'(WIDTH);
    localparam logic [31:0] MAXV     = 32'(MAX_VALUE);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [15:0]         bcd_q, bcd_d;
    logic [15:0]         adj;
    logic [3:0]          cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;
    logic [3:0][5:0]     dig_q, dig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            dig_q      <= {4{OFF}};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            dig_q      <= dig_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        dig_d      = dig_q;
        adj        = bcd_q;

        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d = bus.value;
                    bcd_d   = '0;
                    cnt_d   = CNT_INIT;
                    ovf_d   = ({{(32-WIDTH){1'b0}}, bus.value} > MAXV);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Carry out of the top nibble falls off; only matters on overflow.
                {bcd_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                done_d     = 1'b1;
                overflow_d = ovf_q;
                state_d    = IDLE;
                if (ovf_q) begin
                    dig_d = {4{DASH}};
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        dig_d[i] = {2'b00, bcd_q[4*i +: 4]};
                    end
`ifdef BLANK_LEADING_ZEROS_EN
                    if (bcd_q[15:12] == 4'd0) begin
                        dig_d[3] = OFF;
                        if (bcd_q[11:8] == 4'd0) begin
                            dig_d[2] = OFF;
                            if (bcd_q[7:4] == 4'd0) begin
                                dig_d[1] = OFF;
                            end
                        end
                    end
`else
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.digit3   = dig_q[3];
    assign bus.digit2   = dig_q[2];
    assign bus.digit1   = dig_q[1];
    assign bus.digit0   = dig_q[0];
endmodule

// File: tb/tb_bin_to_digit_converter.sv
// Directed bench for bin_to_digit_converter (WIDTH=14, MAX_VALUE=9999).
// Expected digit codes follow BLANK_LEADING_ZEROS_EN when it is defined.
module tb_bin_to_digit_converter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_to_digit_converter_if #(.WIDTH(14)) bus();

    bin_to_digit_converter #(
        .WIDTH    (14),
        .MAX_VALUE(9999)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

`ifdef BLANK_LEADING_ZEROS_EN
    localparam logic [5:0] Z = 6'd16;
`else
    localparam logic [5:0] Z = 6'd0;
`endif
    localparam logic [5:0] OFF = 6'd16;
    localparam logic [5:0] D   = 6'd17;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [23:0] exp_digits = {4{OFF}};

    function automatic logic [31:0] digs();
        return 32'({bus.digit3, bus.digit2, bus.digit1, bus.digit0});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic convert(input string tag, input logic [13:0] v,
                           input logic [5:0] e3, input logic [5:0] e2,
                           input logic [5:0] e1, input logic [5:0] e0,
                           input logic eo);
        @(negedge clk);
        bus.value = v;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.value = ~v;
        @(negedge clk);
        chk({tag, ".busy_rise"}, 32'(bus.busy), 32'd1);
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk({tag, ".no_early_done"}, 32'(bus.done), 32'd0);
        chk({tag, ".busy_hold"}, 32'(bus.busy), 32'd1);
        chk({tag, ".digits_hold"}, digs(), 32'(exp_digits));
        @(posedge clk);
        @(negedge clk);
        exp_digits = {e3, e2, e1, e0};
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".busy_fall"}, 32'(bus.busy), 32'd0);
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(eo));
        chk({tag, ".digits"}, digs(), 32'(exp_digits));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    int          ndone;
    int          t_done [2];
    logic [23:0] d_done [2];
    logic        o_done [2];
    logic [23:0] held;

    initial begin
        bus.value = '0;
        bus.start = 1'b0;
        #12;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.ovf", 32'(bus.overflow), 32'd0);
        chk("reset.digits", digs(), 32'({4{OFF}}));
        @(negedge clk);
        rst_n = 1'b1;

        convert("v1234", 14'd1234, 6'd1, 6'd2, 6'd3, 6'd4, 1'b0);
        convert("v7", 14'd7, Z, Z, Z, 6'd7, 1'b0);
        convert("v0", 14'd0, Z, Z, Z, 6'd0, 1'b0);
        convert("v1005", 14'd1005, 6'd1, 6'd0, 6'd0, 6'd5, 1'b0);
        convert("v60", 14'd60, Z, Z, 6'd6, 6'd0, 1'b0);
        convert("v9999", 14'd9999, 6'd9, 6'd9, 6'd9, 6'd9, 1'b0);
        convert("v10000", 14'd10000, D, D, D, D, 1'b1);
        convert("v1234b", 14'd1234, 6'd1, 6'd2, 6'd3, 6'd4, 1'b0);

        // start while busy: second request must be dropped
        ndone = 0;
        t_done[0] = 0;
        d_done[0] = '0;
        held = '0;
        @(negedge clk);
        bus.value = 14'd500;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.value = 14'd42;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.value = 14'd0;
        for (int i = 6; i <= 40; i++) begin
            @(posedge clk);
            #2;
            if (i == 14) held = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
            if (bus.done) begin
                if (ndone == 0) begin
                    t_done[0] = i;
                    d_done[0] = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
                end
                ndone++;
            end
        end
        chk("busy_start.held", 32'(held), 32'(exp_digits));
        chk("busy_start.ndone", 32'(ndone), 32'd1);
        chk("busy_start.latency", 32'(t_done[0]), 32'd15);
        exp_digits = {Z, 6'd5, 6'd0, 6'd0};
        chk("busy_start.digits", 32'(d_done[0]), 32'(exp_digits));

        // back-to-back with start held high
        ndone = 0;
        for (int k = 0; k < 2; k++) begin
            t_done[k] = 0;
            d_done[k] = '0;
            o_done[k] = 1'bx;
        end
        @(negedge clk);
        bus.value = 14'd16383;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.value = 14'd255;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #2;
            if (bus.done) begin
                if (ndone < 2) begin
                    t_done[ndone] = i;
                    d_done[ndone] = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
                    o_done[ndone] = bus.overflow;
                end
                ndone++;
            end
        end
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        chk("b2b.ndone", 32'(ndone), 32'd2);
        chk("b2b.t1", 32'(t_done[0]), 32'd15);
        chk("b2b.t2", 32'(t_done[1]), 32'd31);
        chk("b2b.d1", 32'(d_done[0]), 32'({4{D}}));
        chk("b2b.o1", 32'(o_done[0]), 32'd1);
        chk("b2b.d2", 32'(d_done[1]), 32'({Z, 6'd2, 6'd5, 6'd5}));
        chk("b2b.o2", 32'(o_done[1]), 32'd0);
        exp_digits = {Z, 6'd2, 6'd5, 6'd5};

        // asynchronous reset in the middle of SHIFT
        @(negedge clk);
        bus.value = 14'd5678;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.done", 32'(bus.done), 32'd0);
        chk("midrst.ovf", 32'(bus.overflow), 32'd0);
        chk("midrst.digits", digs(), 32'({4{OFF}}));
        #3 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("midrst.no_done", 32'(ndone), 32'd0);
        chk("midrst.digits_after", digs(), 32'({4{OFF}}));
        exp_digits = {4{OFF}};

        convert("v42", 14'd42, Z, Z, 6'd4, 6'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bin_to_digit_converter.md
Name: bin_to_digit_converter

Overview:
- Sequential binary-to-decimal converter placed directly upstream of the four-digit seven-segment display stage.
- Accepts an unsigned binary value with a start pulse and runs a shift-add-3 (double-dabble) conversion, one bit per clock.
- Presents four 6-bit digit codes in the display stage's encoding: 0-9 digit, 16 = OFF (blank), 17 = DASH.
- Output digits hold their value between conversions, so the display never shows partial results.

Parameters:
- WIDTH, 14, bit width of the binary input; legal range 4..14.
- MAX_VALUE, 9999, largest displayable value; inputs above it produce the overflow pattern.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value  input  WIDTH  unsigned binary number to convert; sampled only when start is accepted.
- start  input  1  conversion request, sampled on the rising edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when new digits are valid.
- overflow  output  1  high when the last converted value exceeded MAX_VALUE.
- digit3  output  6  thousands-place code.
- digit2  output  6  hundreds-place code.
- digit1  output  6  tens-place code.
- digit0  output  6  ones-place code.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0; done = 0; overflow = 0.
  - digit3..digit0 = 16 (OFF); internal shift and BCD registers cleared.
- States and transitions:
  - IDLE: if start = 1, latch value into the shift register, clear the 16-bit BCD register, load bit counter = WIDTH, latch ovf = (value > MAX_VALUE), then go to SHIFT. busy rises on that edge.
  - SHIFT: each cycle, add 3 to every BCD nibble that is >= 5, then shift {BCD, shift register} left by 1 and decrement the counter. When the counter reaches 1 on this cycle's shift, go to FORMAT. Exactly WIDTH SHIFT cycles occur.
  - FORMAT: one cycle. Write digit outputs, write overflow = ovf, pulse done = 1, clear busy, go to IDLE.
- Latency:
  - start accepted at edge N; digits, overflow and done update at edge N+WIDTH+1.
  - done is high for exactly one cycle; busy is high for WIDTH+1 cycles.
  - Latency is constant for every input value, including overflow.
- Start rules:
  - start while busy = 1 is ignored; no queuing.
  - start asserted on the same edge that FORMAT completes is also ignored, because the FSM is not yet in IDLE.
  - A start held high continuously therefore begins a new conversion every WIDTH+2 cycles.
  - value changes after acceptance have no effect on the conversion in progress.
- Output formatting (FORMAT):
  - If ovf = 1, all four digits = 17 (DASH). The BCD contents are discarded; a carry out of the top nibble is don't-care.
  - Otherwise each digit = zero-extended BCD nibble, subject to the optional blanking below.
- Digit outputs change only in FORMAT or at reset. They are never glitched mid-conversion.
- Reset mid-conversion aborts immediately: outputs return to reset values and no done pulse is produced.

Optional Feature:
- Macro: BLANK_LEADING_ZEROS_EN.
- Defined:
  - Leading zero digits are output as 16 (OFF), scanning from digit3 downward and stopping at the first non-zero digit.
  - digit0 is never blanked, so a value of 0 displays as OFF,OFF,OFF,0.
  - Zeros after the first non-zero digit are shown as 0.
  - Overflow still shows four DASH codes.
- Not defined: all four digits are shown as decimal values, including leading zeros (0 displays as 0,0,0,0).

Test Plan:
- Reset check: assert rst_n = 0 mid-SHIFT -> busy = 0, done = 0, overflow = 0, all digits = 16 immediately (asynchronous); no done pulse follows.
- Basic conversion: value = 1234, start pulse at edge N -> at edge N+15 (WIDTH = 14) digits = 1,2,3,4; done high for 1 cycle; overflow = 0; busy high for 15 cycles.
- Blanking: value = 7 -> with BLANK_LEADING_ZEROS_EN: 16,16,16,7; without: 0,0,0,7. Value = 0 -> 16,16,16,0 with the macro, 0,0,0,0 without. Value = 1005 -> 1,0,0,5 in both builds.
- Range boundary: value = 9999 -> digits 9,9,9,9 and overflow = 0; value = 10000 -> digits 17,17,17,17 and overflow = 1, with the same 15-cycle latency.
- Start while busy: start pulse, then value = 42 with start asserted 5 cycles later -> only the first result appears and exactly one done pulse occurs; digits are unchanged until that done.
- Back-to-back: start held high with value = 16383 then 255 -> dashes and overflow = 1 first; then 0,2,5,5 (or 16,2,5,5 with the macro) and overflow = 0; done pulses are 16 cycles apart.
